// File: rtl/conv_matrix_loader.sv
// rtl/conv_matrix_loader.sv - gathers pixel and kernel bytes into 5x5 row-major matrices for the convolution stage
module conv_matrix_loader #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [1:0]                            cfg_size,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_W-1:0]                     in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [MAX_DIM*MAX_DIM*DATA_W-1:0]     matrix_a,
    output logic [MAX_DIM*MAX_DIM*DATA_W-1:0]     matrix_b,
    output logic [1:0]                            matrix_size,
    output logic                                  busy
);

    localparam int MAT_W = MAX_DIM * MAX_DIM * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         row_q, row_d;
    logic [2:0]         col_q, col_d;
    logic [MAT_W-1:0]   mat_a_q, mat_a_d;
    logic [MAT_W-1:0]   mat_b_q, mat_b_d;
    logic [1:0]         size_q, size_d;

    // Highest row/col index for the latched dimension (N-1 = cfg_size+1).
    logic [2:0]         last_rc;
    // Byte slot of the current element; 5 bits covers index 24.
    logic [4:0]         idx;

    assign last_rc = {1'b0, size_q} + 3'd1;
    assign idx     = ({2'b00, row_q} * 5'(MAX_DIM)) + {2'b00, col_q};

    // Next-state, counter, matrix-write and handshake decode.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        mat_a_d   = mat_a_q;
        mat_b_d   = mat_b_q;
        size_d    = size_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Clearing here guarantees zero padding outside NxN even after a larger load.
                    size_d  = cfg_size;
                    mat_a_d = '0;
                    mat_b_d = '0;
                    row_d   = 3'd0;
                    col_d   = 3'd0;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (state_q == S_LOAD_A) begin
                        mat_a_d[idx*DATA_W +: DATA_W] = in_data;
                    end else begin
                        mat_b_d[idx*DATA_W +: DATA_W] = in_data;
                    end
                    if (col_q == last_rc) begin
                        col_d = 3'd0;
                        if (row_q == last_rc) begin
                            row_d   = 3'd0;
                            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_HOLD;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and matrix storage; reset drops any partial load at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            mat_a_q <= '0;
            mat_b_q <= '0;
            size_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            mat_a_q <= mat_a_d;
            mat_b_q <= mat_b_d;
            size_q  <= size_d;
        end
    end

    assign matrix_a    = mat_a_q;
    assign matrix_b    = mat_b_q;
    assign matrix_size = size_q;
    assign busy        = (state_q != S_IDLE);

endmodule
